// File: rtl/ibex_cosim_dside_tracker.sv
// Purpose: track data-side bus requests in grant order and emit one completed-access record per response.
// Latency: notify_valid_o pulses one cycle after the rvalid_i cycle that retires the oldest outstanding request.
// Backpressure: none; a grant while full (no same-cycle retire) is dropped and flagged sticky via overflow_o.
// Optional: define DSIDE_TRACKER_RDATA_MASK_EN to zero load-data bytes whose stored byte enable is 0.
module ibex_cosim_dside_tracker #(
    parameter int unsigned  AddrWidth      = 32,
    parameter int unsigned  DataWidth      = 32,
    parameter int unsigned  MaxOutstanding = 2,
    localparam int unsigned BeWidth        = DataWidth / 8,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 gnt_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 misaligned_first_i,
    input  logic                 misaligned_second_i,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    input  logic                 err_i,
    output logic                 notify_valid_o,
    output logic                 notify_we_o,
    output logic [AddrWidth-1:0] notify_addr_o,
    output logic [DataWidth-1:0] notify_data_o,
    output logic [BeWidth-1:0]   notify_be_o,
    output logic                 notify_err_o,
    output logic                 notify_mis_first_o,
    output logic                 notify_mis_second_o,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 full_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int unsigned         PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [BeWidth-1:0]   be;
        logic [DataWidth-1:0] wdata;
        logic                 mis_first;
        logic                 mis_second;
    } entry_t;

    entry_t               mem_q [MaxOutstanding];
    entry_t               head;
    entry_t               new_entry;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full, empty, grant, push, pop;
    logic [DataWidth-1:0] load_data;

    logic                 nv_q, nv_d;
    logic                 nwe_q, nwe_d;
    logic [AddrWidth-1:0] naddr_q, naddr_d;
    logic [DataWidth-1:0] ndata_q, ndata_d;
    logic [BeWidth-1:0]   nbe_q, nbe_d;
    logic                 nerr_q, nerr_d;
    logic                 nmf_q, nmf_d;
    logic                 nms_q, nms_d;

    assign full      = (cnt_q == MaxCnt);
    assign empty     = (cnt_q == '0);
    assign grant     = req_i & gnt_i;
    // Retiring frees a slot this cycle, so a grant alongside a retire is legal even when full.
    // A grant into an empty FIFO cannot satisfy a same-cycle rvalid: empty gates the pop.
    assign pop       = rvalid_i & ~empty;
    assign push      = grant & (~full | pop);
    assign head      = mem_q[rd_ptr_q];
    assign new_entry = '{we: we_i, addr: addr_i, be: be_i, wdata: wdata_i,
                         mis_first: misaligned_first_i, mis_second: misaligned_second_i};

    // Load data as reported: raw rdata, or with disabled bytes zeroed when masking is built in.
    always_comb begin
        load_data = rdata_i;
`ifdef DSIDE_TRACKER_RDATA_MASK_EN
        for (int b = 0; b < int'(BeWidth); b++) begin
            if (!head.be[b]) begin
                load_data[8*b +: 8] = 8'h00;
            end
        end
`endif
    end

    // Next-state for pointers (wrap at MaxOutstanding, not at a power of two), count and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (grant & full & ~pop);
        unf_d    = unf_q | (rvalid_i & empty);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Next-state for the notification record; fields hold between pulses.
    always_comb begin
        nv_d    = pop;
        nwe_d   = nwe_q;
        naddr_d = naddr_q;
        ndata_d = ndata_q;
        nbe_d   = nbe_q;
        nerr_d  = nerr_q;
        nmf_d   = nmf_q;
        nms_d   = nms_q;
        if (pop) begin
            nwe_d   = head.we;
            naddr_d = head.addr;
            ndata_d = head.we ? head.wdata : load_data;
            nbe_d   = head.be;
            nerr_d  = err_i;
            nmf_d   = head.mis_first;
            nms_d   = head.mis_second;
        end
    end

    // Control and record state, cleared asynchronously so a reset drops every outstanding entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            nv_q     <= 1'b0;
            nwe_q    <= 1'b0;
            naddr_q  <= '0;
            ndata_q  <= '0;
            nbe_q    <= '0;
            nerr_q   <= 1'b0;
            nmf_q    <= 1'b0;
            nms_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            nv_q     <= nv_d;
            nwe_q    <= nwe_d;
            naddr_q  <= naddr_d;
            ndata_q  <= ndata_d;
            nbe_q    <= nbe_d;
            nerr_q   <= nerr_d;
            nmf_q    <= nmf_d;
            nms_q    <= nms_d;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign notify_valid_o      = nv_q;
    assign notify_we_o         = nwe_q;
    assign notify_addr_o       = naddr_q;
    assign notify_data_o       = ndata_q;
    assign notify_be_o         = nbe_q;
    assign notify_err_o        = nerr_q;
    assign notify_mis_first_o  = nmf_q;
    assign notify_mis_second_o = nms_q;
    assign outstanding_o       = cnt_q;
    assign full_o              = full;
    assign overflow_o          = ovf_q;
    assign underflow_o         = unf_q;

endmodule

// File: tb/tb_ibex_cosim_dside_tracker.sv
// Purpose: exercise ibex_cosim_dside_tracker (MaxOutstanding=3) against a queue-based reference model.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: n/a; stimulus includes overflow, underflow and asynchronous reset pulses.
module tb_ibex_cosim_dside_tracker;

    localparam int MAXO = 3;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit        mf;
        bit        ms;
    } acc_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, gnt_i, we_i;
    logic [31:0] addr_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        misaligned_first_i, misaligned_second_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;
    logic        notify_valid_o, notify_we_o;
    logic [31:0] notify_addr_o, notify_data_o;
    logic [3:0]  notify_be_o;
    logic        notify_err_o, notify_mis_first_o, notify_mis_second_o;
    logic [1:0]  outstanding_o;
    logic        full_o, overflow_o, underflow_o;

    ibex_cosim_dside_tracker #(
        .AddrWidth      (32),
        .DataWidth      (32),
        .MaxOutstanding (MAXO)
    ) u_dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .req_i               (req_i),
        .gnt_i               (gnt_i),
        .we_i                (we_i),
        .addr_i              (addr_i),
        .be_i                (be_i),
        .wdata_i             (wdata_i),
        .misaligned_first_i  (misaligned_first_i),
        .misaligned_second_i (misaligned_second_i),
        .rvalid_i            (rvalid_i),
        .rdata_i             (rdata_i),
        .err_i               (err_i),
        .notify_valid_o      (notify_valid_o),
        .notify_we_o         (notify_we_o),
        .notify_addr_o       (notify_addr_o),
        .notify_data_o       (notify_data_o),
        .notify_be_o         (notify_be_o),
        .notify_err_o        (notify_err_o),
        .notify_mis_first_o  (notify_mis_first_o),
        .notify_mis_second_o (notify_mis_second_o),
        .outstanding_o       (outstanding_o),
        .full_o              (full_o),
        .overflow_o          (overflow_o),
        .underflow_o         (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: outstanding accesses in grant order plus the last reported record.
    acc_t      mq[$];
    bit        m_nv, m_we, m_err, m_mf, m_ms, m_ovf, m_unf;
    bit [31:0] m_addr, m_data;
    bit [3:0]  m_be;
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] load_view(bit [31:0] rd, bit [3:0] be);
        bit [31:0] r = rd;
`ifdef DSIDE_TRACKER_RDATA_MASK_EN
        for (int b = 0; b < 4; b++) begin
            if (!be[b]) r[8*b +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_nv = 0; m_we = 0; m_err = 0; m_mf = 0; m_ms = 0;
        m_ovf = 0; m_unf = 0; m_addr = '0; m_data = '0; m_be = '0;
    endfunction

    // One clock of the model, using the inputs the bench is currently driving.
    function automatic void model_step();
        int   sz = mq.size();
        bit   retired = rvalid_i && (sz > 0);
        acc_t h;
        m_nv = 0;
        if (rvalid_i && sz == 0) m_unf = 1;
        if (retired) begin
            h      = mq.pop_front();
            m_nv   = 1;
            m_we   = h.we;
            m_addr = h.addr;
            m_be   = h.be;
            m_mf   = h.mf;
            m_ms   = h.ms;
            m_err  = err_i;
            m_data = h.we ? h.wdata : load_view(rdata_i, h.be);
        end
        if (req_i && gnt_i) begin
            if (sz < MAXO || retired) begin
                h = '{we: we_i, addr: addr_i, be: be_i, wdata: wdata_i,
                      mf: misaligned_first_i, ms: misaligned_second_i};
                mq.push_back(h);
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic compare_all();
        check("notify_valid", notify_valid_o, m_nv);
        check("notify_we", notify_we_o, m_we);
        check("notify_addr", notify_addr_o, m_addr);
        check("notify_data", notify_data_o, m_data);
        check("notify_be", notify_be_o, m_be);
        check("notify_err", notify_err_o, m_err);
        check("notify_mis_first", notify_mis_first_o, m_mf);
        check("notify_mis_second", notify_mis_second_o, m_ms);
        check("outstanding", outstanding_o, mq.size());
        check("full", full_o, mq.size() == MAXO);
        check("overflow", overflow_o, m_ovf);
        check("underflow", underflow_o, m_unf);
    endtask

    task automatic cycle(input bit rq, input bit gn, input acc_t a,
                         input bit rv, input bit [31:0] rd, input bit er);
        req_i = rq; gnt_i = gn; we_i = a.we; addr_i = a.addr; be_i = a.be;
        wdata_i = a.wdata; misaligned_first_i = a.mf; misaligned_second_i = a.ms;
        rvalid_i = rv; rdata_i = rd; err_i = er;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    function automatic acc_t mk(bit we, bit [31:0] addr, bit [3:0] be, bit [31:0] wd);
        acc_t a = '{we: we, addr: addr, be: be, wdata: wd, mf: 1'b0, ms: 1'b0};
        return a;
    endfunction

    task automatic idle();
        cycle(0, 0, mk(0, 0, 0, 0), 0, 0, 0);
    endtask

    task automatic rsp(input bit [31:0] rd, input bit er);
        cycle(0, 0, mk(0, 0, 0, 0), 1, rd, er);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_ni = 1'b1;
    endtask

    acc_t      ra;
    bit [31:0] exp_mask;

    initial begin
        req_i = 0; gnt_i = 0; we_i = 0; addr_i = '0; be_i = '0; wdata_i = '0;
        misaligned_first_i = 0; misaligned_second_i = 0;
        rvalid_i = 0; rdata_i = '0; err_i = 0;
        rst_ni = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single load answered two cycles after grant.
        cycle(1, 1, mk(0, 32'h100, 4'hF, 32'h0), 0, 0, 0);
        idle();
        rsp(32'hDEADBEEF, 0);
        check("s1_valid", notify_valid_o, 1);
        check("s1_we", notify_we_o, 0);
        check("s1_addr", notify_addr_o, 32'h100);
        check("s1_data", notify_data_o, 32'hDEADBEEF);
        check("s1_err", notify_err_o, 0);
        idle();
        check("s1_pulse_len", notify_valid_o, 0);

        // Three back-to-back stores then three responses, in order.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, mk(1, 32'(4 * i), 4'hF, 32'h1000 + 32'(i)), 0, 0, 0);
            check("s2_count_up", outstanding_o, i + 1);
            check("s2_full_up", full_o, i == 2);
        end
        for (int i = 0; i < 3; i++) begin
            rsp(32'hFFFF_FFFF, 0);
            check("s2_addr_order", notify_addr_o, 4 * i);
            check("s2_store_data", notify_data_o, 32'h1000 + i);
            check("s2_count_down", outstanding_o, 2 - i);
            check("s2_full_down", full_o, 0);
        end

        // Full: grant with same-cycle retire is legal; grant alone is dropped.
        for (int i = 0; i < 3; i++) cycle(1, 1, mk(0, 32'h200 + 32'(4 * i), 4'hF, 0), 0, 0, 0);
        cycle(1, 1, mk(0, 32'h300, 4'hF, 0), 1, 32'h11, 0);
        check("s3_count_swap", outstanding_o, 3);
        check("s3_no_ovf", overflow_o, 0);
        cycle(1, 1, mk(0, 32'h400, 4'hF, 0), 0, 0, 0);
        check("s3_ovf", overflow_o, 1);
        check("s3_count_drop", outstanding_o, 3);
        rsp(32'h22, 1);
        check("s3_err", notify_err_o, 1);
        rsp(32'h33, 0);
        rsp(32'h44, 0);
        check("s3_last_addr", notify_addr_o, 32'h300);

        // Underflow then a normal load.
        rsp(32'h55, 0);
        check("s4_unf", underflow_o, 1);
        check("s4_no_notify", notify_valid_o, 0);
        cycle(1, 1, mk(0, 32'h500, 4'hF, 0), 0, 0, 0);
        rsp(32'h12345678, 0);
        check("s4_data", notify_data_o, 32'h12345678);
        check("s4_unf_sticky", underflow_o, 1);

        // Partial byte enables on a load.
        cycle(1, 1, mk(0, 32'h600, 4'h3, 0), 0, 0, 0);
        rsp(32'hAABBCCDD, 0);
`ifdef DSIDE_TRACKER_RDATA_MASK_EN
        exp_mask = 32'h0000CCDD;
`else
        exp_mask = 32'hAABBCCDD;
`endif
        check("s5_mask", notify_data_o, exp_mask);

        // Reset with two loads outstanding; later response is underflow.
        cycle(1, 1, mk(0, 32'h700, 4'hF, 0), 0, 0, 0);
        cycle(1, 1, mk(0, 32'h704, 4'hF, 0), 0, 0, 0);
        reset_pulse();
        check("s6_count", outstanding_o, 0);
        idle();
        check("s6_no_notify", notify_valid_o, 0);
        rsp(32'h99, 0);
        check("s6_unf", underflow_o, 1);
        check("s6_no_notify2", notify_valid_o, 0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            ra.we    = 1'($urandom_range(0, 1));
            ra.addr  = $urandom & 32'hFFFF_FFFC;
            ra.be    = 4'($urandom);
            ra.wdata = $urandom;
            ra.mf    = 1'($urandom_range(0, 1));
            ra.ms    = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, ra,
                  $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibex_cosim_dside_tracker.md
IBEX_COSIM_DSIDE_TRACKER -- requirements
Module: ibex_cosim_dside_tracker

Interface
REQ-001 SHALL have parameters, one per line:
- AddrWidth, 32, address width.
- DataWidth, 32, data width; BeWidth = DataWidth/8.
- MaxOutstanding, 2, maximum granted-but-unanswered requests; legal range 1..16.
REQ-002 SHALL have ports, one per line:
- clk_i in 1, sole clock.
- rst_ni in 1, asynchronous active-low reset.
- req_i in 1, request.
- gnt_i in 1, grant.
- we_i in 1, write enable.
- addr_i in AddrWidth, address.
- be_i in BeWidth, byte enables.
- wdata_i in DataWidth, write data.
- misaligned_first_i in 1, first half of a split access.
- misaligned_second_i in 1, second half of a split access.
- rvalid_i in 1, response valid.
- rdata_i in DataWidth, read data.
- err_i in 1, bus error.
- notify_valid_o out 1, completed-access record valid (one-cycle pulse).
- notify_we_o out 1, record is a store.
- notify_addr_o out AddrWidth, record address.
- notify_data_o out DataWidth, record data.
- notify_be_o out BeWidth, record byte enables.
- notify_err_o out 1, record bus error.
- notify_mis_first_o out 1, record misaligned-first flag.
- notify_mis_second_o out 1, record misaligned-second flag.
- outstanding_o out $clog2(MaxOutstanding+1), current outstanding count.
- full_o out 1, outstanding_o == MaxOutstanding.
- overflow_o out 1, sticky: grant accepted while full.
- underflow_o out 1, sticky: rvalid_i with no outstanding request.

Function
REQ-003 SHALL push {we, addr, be, wdata, mis_first, mis_second} into an in-order FIFO of depth MaxOutstanding on every cycle with req_i & gnt_i.
REQ-004 SHALL pop the FIFO head on every cycle with rvalid_i and a non-empty FIFO; responses SHALL be matched to requests strictly in grant order.
REQ-005 SHALL drive the notify_* outputs from a register, with notify_valid_o high exactly one cycle after the popping rvalid_i cycle.
REQ-006 SHALL set notify_data_o to the stored wdata for stores and to the rdata_i sampled at rvalid_i for loads.
REQ-007 SHALL set notify_err_o to the err_i sampled at rvalid_i, regardless of access type.
REQ-008 SHALL hold the notify_* fields stable when notify_valid_o is low.
REQ-009 Simultaneous push and pop SHALL both take effect: count unchanged; legal when full; on an empty FIFO the pop is not satisfied by the same-cycle push.
REQ-010 rvalid_i on an empty FIFO SHALL set underflow_o, produce no notification, and leave the count unchanged.
REQ-011 A grant while full without a same-cycle pop SHALL set overflow_o and drop the request; FIFO contents and count are unchanged.
REQ-012 overflow_o and underflow_o SHALL stay set until reset.
REQ-013 FIFO read and write pointers SHALL wrap modulo MaxOutstanding, including when MaxOutstanding is not a power of two.
REQ-014 outstanding_o and full_o SHALL reflect the registered state, updated at the clock edge after each push or pop.

Reset
REQ-015 Asserting rst_ni low SHALL immediately clear the FIFO pointers and count, notify_valid_o, overflow_o and underflow_o; all other notify_* outputs SHALL reset to 0.
REQ-016 Reset mid-operation SHALL discard all outstanding entries; a response arriving after reset SHALL be treated as underflow.

Configuration
REQ-017 With DSIDE_TRACKER_RDATA_MASK_EN defined, load notify_data_o SHALL zero every byte whose stored be bit is 0; undefined, rdata_i SHALL pass through unmasked; store data is never masked.

Verification
REQ-018 Scenarios a bench SHALL cover:
- Load to 0x100 with be=0xF, granted; rvalid with rdata=0xDEADBEEF two cycles later -> one notify pulse: we=0, addr=0x100, data=0xDEADBEEF, err=0.
- MaxOutstanding=3: stores to 0x0, 0x4, 0x8 granted back-to-back, then 3 rvalids -> 3 notifications in address order; outstanding_o goes 1,2,3,2,1,0; full_o high only at 3.
- Full FIFO with a grant and an rvalid in the same cycle -> count stays 3, overflow_o stays 0; a grant while full with no rvalid -> overflow_o=1, request dropped.
- rvalid with an empty FIFO -> underflow_o=1, no notify pulse; then a normal load -> notified correctly, underflow_o still 1.
- Macro defined: load with be=0x3, rdata=0xAABBCCDD -> data=0x0000CCDD; macro undefined -> data=0xAABBCCDD.
- Two loads outstanding, then rst_ni pulsed low -> count=0 and no notify pulse; a following rvalid -> underflow_o=1.
